// File: rtl/router_pkg.sv
// Shared router types: handshake FSM states and default input buffer sizing.
package router_pkg;
  typedef enum logic [0:0] {IN_IDLE = 1'b0, IN_ACK = 1'b1} in_state_t;
  typedef enum logic [1:0] {OUT_IDLE = 2'd0, OUT_REQ = 2'd1, OUT_WAIT = 2'd2} out_state_t;
  localparam int RT_BUF_DEPTH = 4;
  localparam int RT_FLIT_W    = 32;
endpackage

// File: rtl/rt_fifo.sv
// In-order flit storage: wrap-around pointers plus a separate occupancy counter.
module rt_fifo
  import router_pkg::*;
#(
  parameter int WIDTH = RT_FLIT_W,
  parameter int DEPTH = RT_BUF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + AW'(1);
      if (pop)  r_rptr <= r_rptr + AW'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rdata = r_mem[r_rptr];
  assign count = r_count;
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
endmodule

// File: rtl/rt_input_buffer.sv
// Per-port input buffer: 4-phase req/ack in, FIFO, 4-phase req/ack out to the core.
module rt_input_buffer
  import router_pkg::*;
#(
  parameter int WIDTH = RT_FLIT_W,
  parameter int DEPTH = RT_BUF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_req,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ack,
  output logic                     out_req,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  in_state_t        r_in_st;
  out_state_t       r_out_st;
  logic             r_in_ack;
  logic             r_out_req;
  logic [WIDTH-1:0] r_out_data;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head;
  logic             w_full;
  logic             w_empty;

  // Full is the pre-edge value, so a same-edge pop never frees a slot for a push.
  assign w_push = (r_in_st == IN_IDLE) && in_req && !w_full;
  assign w_pop  = (r_out_st == OUT_REQ) && out_ack;

  rt_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (in_data),
    .rdata (w_head),
    .count (count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_st  <= IN_IDLE;
      r_in_ack <= 1'b0;
    end else begin
      case (r_in_st)
        IN_IDLE: if (w_push) begin
          r_in_ack <= 1'b1;
          r_in_st  <= IN_ACK;
        end
        IN_ACK: if (!in_req) begin
          r_in_ack <= 1'b0;
          r_in_st  <= IN_IDLE;
        end
        default: begin
          r_in_ack <= 1'b0;
          r_in_st  <= IN_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_st   <= OUT_IDLE;
      r_out_req  <= 1'b0;
      r_out_data <= '0;
    end else begin
      case (r_out_st)
        OUT_IDLE: if (!w_empty) begin
          r_out_data <= w_head;
          r_out_req  <= 1'b1;
          r_out_st   <= OUT_REQ;
        end
        OUT_REQ: if (out_ack) begin
          r_out_req <= 1'b0;
          r_out_st  <= OUT_WAIT;
        end
        OUT_WAIT: if (!out_ack) r_out_st <= OUT_IDLE;
        default: begin
          r_out_req <= 1'b0;
          r_out_st  <= OUT_IDLE;
        end
      endcase
    end
  end

  assign in_ack   = r_in_ack;
  assign out_req  = r_out_req;
  assign out_data = r_out_data;
  assign full     = w_full;
  assign empty    = w_empty;
endmodule

// File: tb/tb_rt_input_buffer.sv
// Bench for rt_input_buffer: vector table, directed corner sequences, random streams vs a queue model.
module tb_rt_input_buffer;
  localparam int W = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_req;
  logic [W-1:0] in_data;
  logic         in_ack;
  logic         out_req;
  logic [W-1:0] out_data;
  logic         out_ack;
  logic [2:0]   count;
  logic         full;
  logic         empty;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] expq[$];
  bit mon_en = 0;
  int occ = 0;
  logic p_ack = 1'b0, p_req = 1'b0;

  always #5 clk = ~clk;

  rt_input_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
    .out_req(out_req), .out_data(out_data), .out_ack(out_ack),
    .count(count), .full(full), .empty(empty)
  );

  typedef struct {
    logic         in_req;
    logic [W-1:0] in_data;
    logic         out_ack;
    logic         e_in_ack;
    logic         e_out_req;
    logic [2:0]   e_count;
    logic         chk_data;
    logic [W-1:0] e_data;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timeout at %0t", nm, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Occupancy model: a flit enters when in_ack rises and leaves when out_req falls.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      occ = 0; p_ack = 1'b0; p_req = 1'b0;
    end else begin
      if (in_ack && !p_ack) occ++;
      if (!out_req && p_req) occ--;
      p_ack = in_ack;
      p_req = out_req;
      if (mon_en) begin
        chk("mon_count", 64'(count), 64'(occ));
        chk("mon_full", 64'(full), 64'(occ == D));
        chk("mon_empty", 64'(empty), 64'(occ == 0));
      end
    end
  end

  task automatic up_send(input logic [W-1:0] d, input int gap);
    int n;
    repeat (gap) tick();
    in_data = d;
    in_req = 1'b1;
    n = 0;
    while (!in_ack && n < 200) begin tick(); n++; end
    if (!in_ack) begin tmo("up_ack"); in_req = 1'b0; return; end
    expq.push_back(d);
    in_req = 1'b0;
    n = 0;
    while (in_ack && n < 20) begin tick(); n++; end
    if (in_ack) tmo("up_release");
  endtask

  task automatic dn_recv(input int dly, output logic [W-1:0] d);
    int n;
    n = 0;
    d = '0;
    while (!out_req && n < 200) begin tick(); n++; end
    if (!out_req) begin tmo("dn_req"); return; end
    d = out_data;
    if (expq.size() == 0) tmo("order_underflow");
    else chk("order", 64'(d), 64'(expq.pop_front()));
    repeat (dly) begin
      tick();
      chk("hold_req", 64'(out_req), 64'd1);
      chk("hold_data", 64'(out_data), 64'(d));
    end
    out_ack = 1'b1;
    n = 0;
    do begin tick(); n++; end while (out_req && n < 20);
    if (out_req) tmo("dn_pop");
    out_ack = 1'b0;
  endtask

  task automatic stream(input int nflits, input bit rnd_data, input int maxgap, input int maxdly);
    fork
      begin
        for (int i = 0; i < nflits; i++)
          up_send(rnd_data ? W'($urandom) : W'(i), $urandom_range(0, maxgap));
      end
      begin
        logic [W-1:0] r;
        for (int j = 0; j < nflits; j++) dn_recv($urandom_range(0, maxdly), r);
      end
    join
  endtask

  initial begin
    logic [W-1:0] d;
    int n;
    // Test 1 (single flit latency) followed by test 6 (out_ack while empty and idle).
    vecs[0] = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'hA5A5_0001, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 32'hA5A5_0001};
    vecs[2] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0};

    rst_n = 1'b0; in_req = 1'b0; in_data = '0; out_ack = 1'b0;
    #12;
    chk("rst_in_ack", 64'(in_ack), 64'd0);
    chk("rst_out_req", 64'(out_req), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      in_req = vecs[i].in_req; in_data = vecs[i].in_data; out_ack = vecs[i].out_ack;
      tick();
      chk($sformatf("vec%0d_in_ack", i), 64'(in_ack), 64'(vecs[i].e_in_ack));
      chk($sformatf("vec%0d_out_req", i), 64'(out_req), 64'(vecs[i].e_out_req));
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].e_count));
      chk($sformatf("vec%0d_empty", i), 64'(empty), 64'(vecs[i].e_count == 0));
      if (vecs[i].chk_data) chk($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].e_data));
    end

    // Test 2: fill with the core stalled, then one pop lets the waiting flit in.
    for (int i = 0; i < 4; i++) up_send(W'(32'h20 + i), 0);
    chk("t2_count_full", 64'(count), 64'd4);
    chk("t2_full", 64'(full), 64'd1);
    in_data = 32'h24; in_req = 1'b1;
    repeat (5) tick();
    chk("t2_blocked_ack", 64'(in_ack), 64'd0);
    chk("t2_blocked_count", 64'(count), 64'd4);
    chk("t2_head", 64'(out_data), 64'h20);
    out_ack = 1'b1;
    tick();
    chk("t2_pop_req", 64'(out_req), 64'd0);
    chk("t2_pop_count", 64'(count), 64'd3);
    d = expq.pop_front();
    out_ack = 1'b0;
    n = 0;
    while (!in_ack && n < 2) begin tick(); n++; end
    chk("t2_late_ack", 64'(in_ack), 64'd1);
    if (in_ack) expq.push_back(32'h24);
    in_req = 1'b0;
    tick();
    chk("t2_refill_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      dn_recv(0, d);
      chk($sformatf("t2_drain%0d", i), 64'(d), 64'(32'h21 + i));
    end
    tick();

    // Test 3: ordered stream with random core delays and pointer wrap.
    mon_en = 1;
    stream(10, 1'b0, 2, 5);
    tick();
    chk("t3_count", 64'(count), 64'd0);
    chk("t3_empty", 64'(empty), 64'd1);
    chk("t3_q_empty", 64'(expq.size()), 64'd0);
    mon_en = 0;

    // Test 4: push and pop on the same edge at count 2.
    up_send(32'h40, 0);
    up_send(32'h41, 0);
    chk("t4_pre_count", 64'(count), 64'd2);
    chk("t4_head", 64'(out_data), 64'h40);
    d = expq.pop_front();
    in_data = 32'h42; in_req = 1'b1; out_ack = 1'b1;
    tick();
    chk("t4_count", 64'(count), 64'd2);
    chk("t4_full", 64'(full), 64'd0);
    chk("t4_empty", 64'(empty), 64'd0);
    chk("t4_in_ack", 64'(in_ack), 64'd1);
    chk("t4_out_req", 64'(out_req), 64'd0);
    expq.push_back(32'h42);
    in_req = 1'b0; out_ack = 1'b0;
    tick();
    dn_recv(1, d); chk("t4_d41", 64'(d), 64'h41);
    dn_recv(0, d); chk("t4_d42", 64'(d), 64'h42);
    tick();

    // Test 5: asynchronous reset in the middle of both handshakes.
    up_send(32'h51, 0);
    up_send(32'h52, 0);
    in_data = 32'h53; in_req = 1'b1;
    tick();
    chk("t5_pre_in_ack", 64'(in_ack), 64'd1);
    chk("t5_pre_out_req", 64'(out_req), 64'd1);
    chk("t5_pre_count", 64'(count), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_in_ack", 64'(in_ack), 64'd0);
    chk("t5_out_req", 64'(out_req), 64'd0);
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_empty", 64'(empty), 64'd1);
    expq.delete();
    in_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    up_send(32'h1234, 0);
    dn_recv(0, d);
    chk("t5_post_data", 64'(d), 64'h1234);
    tick(); tick();
    chk("t5_post_count", 64'(count), 64'd0);

    // Random stress against the queue and occupancy model.
    mon_en = 1;
    stream(40, 1'b1, 3, 4);
    stream(20, 1'b1, 0, 0);
    tick();
    mon_en = 0;
    chk("rnd_count", 64'(count), 64'd0);
    chk("rnd_q_empty", 64'(expq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: time %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
